// File: rtl/store_buffer_pkg.sv
// Shared constants and types for the word store buffer and its forwarding search.
package store_buffer_pkg;

    localparam int SB_DATA_WIDTH = 32;
    localparam int SB_DEPTH      = 4;
    localparam int SB_PTR_WIDTH  = 2;

    // Base of the data segment; DataMemory owns the translation to its local index.
    localparam logic [31:0] DATA_BASE_ADDRESS = 32'h1001_0000;

    // Owner of the single DataMemory port in a given cycle.
    typedef enum logic [1:0] {
        PORT_IDLE  = 2'd0,
        PORT_LOAD  = 2'd1,
        PORT_DRAIN = 2'd2
    } port_op_e;

endpackage

// File: rtl/store_forward_match.sv
// Youngest-first search of the buffered stores for a word address that matches a load.
// Callers pass word addresses (byte offset already stripped), so misaligned loads
// still hit on the containing word.
module store_forward_match
    import store_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = SB_DATA_WIDTH,
    parameter int DEPTH      = SB_DEPTH,
    parameter int PTR_WIDTH  = SB_PTR_WIDTH
) (
    input  logic [DEPTH-1:0][DATA_WIDTH-3:0] entry_word,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0] entry_data,
    input  logic [DEPTH-1:0]                 entry_valid,
    input  logic [PTR_WIDTH-1:0]             head,
    input  logic [DATA_WIDTH-3:0]            load_word,
    output logic                             hit,
    output logic [DATA_WIDTH-1:0]            data
);

    logic [PTR_WIDTH-1:0] idx;

    // Walk oldest to youngest starting at head; a later match overrides, so the youngest wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_WIDTH'(k);
            if (entry_valid[idx] && (entry_word[idx] == load_word)) begin
                hit  = 1'b1;
                data = entry_data[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order word store buffer in front of DataMemory with same-cycle load forwarding.
// Handshake: a store transfers at the rising edge where StoreValid && StoreReady are
// both high; StoreValid must hold its address/data until that edge (the pipeline
// stalls while StoreReady is low). Loads have no handshake: LoadValid always wins the
// memory port and the result is combinational in the same cycle.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = SB_DATA_WIDTH,
    parameter int DEPTH      = SB_DEPTH,
    parameter int PTR_WIDTH  = SB_PTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  StoreValid,
    input  logic [DATA_WIDTH-1:0] StoreAddress,
    input  logic [DATA_WIDTH-1:0] StoreData,
    output logic                  StoreReady,
    input  logic                  LoadValid,
    input  logic [DATA_WIDTH-1:0] LoadAddress,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  LoadHit,
    output logic                  MemWrite,
    output logic                  MemRead,
    output logic [DATA_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0] MemWriteData,
    input  logic [DATA_WIDTH-1:0] MemReadData,
    output logic                  Empty,
    output logic                  Full,
    output logic [PTR_WIDTH:0]    Count
);

    localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] addr_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
    logic [DEPTH-1:0][DATA_WIDTH-3:0] entry_word;
    logic [DEPTH-1:0]                 entry_valid;
    logic [PTR_WIDTH-1:0]             head_q;
    logic [PTR_WIDTH-1:0]             tail_q;
    logic [PTR_WIDTH:0]               count_q;
    logic                             drain;
    logic                             enqueue;
    logic                             fwd_hit;
    logic [DATA_WIDTH-1:0]            fwd_data;
    port_op_e                         port_op;

    assign Count = count_q;
    assign Empty = (count_q == '0);
    assign Full  = (count_q == FULL_COUNT);

    // A load owns the memory port, so the buffer only drains in load-free cycles.
    assign drain      = !Empty && !LoadValid && reset;
    assign StoreReady = reset && (!Full || drain);
    assign enqueue    = StoreValid && StoreReady;

    // An entry is live when its distance from head is below the occupancy count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic [PTR_WIDTH-1:0] offset;
        assign offset         = PTR_WIDTH'(g) - head_q;
        assign entry_valid[g] = ({1'b0, offset} < count_q);
        assign entry_word[g]  = addr_q[g][DATA_WIDTH-1:2];
    end

    store_forward_match #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_match (
        .entry_word  (entry_word),
        .entry_data  (data_q),
        .entry_valid (entry_valid),
        .head        (head_q),
        .load_word   (LoadAddress[DATA_WIDTH-1:2]),
        .hit         (fwd_hit),
        .data        (fwd_data)
    );

    // Pointers and occupancy; reset discards every buffered store.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enqueue) tail_q <= tail_q + PTR_WIDTH'(1);
            if (drain)   head_q <= head_q + PTR_WIDTH'(1);
            case ({enqueue, drain})
                2'b10:   count_q <= count_q + (PTR_WIDTH + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_WIDTH + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage is written on enqueue only and is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (enqueue) begin
            addr_q[tail_q] <= StoreAddress;
            data_q[tail_q] <= StoreData;
        end
    end

    // Memory port arbitration: load first, then drain of the oldest entry, else idle.
    always_comb begin
        port_op = PORT_IDLE;
        if (LoadValid) begin
            port_op = PORT_LOAD;
        end else if (drain) begin
            port_op = PORT_DRAIN;
        end
        MemRead      = (port_op == PORT_LOAD);
        MemWrite     = (port_op == PORT_DRAIN);
        MemAddress   = (port_op == PORT_LOAD) ? LoadAddress : addr_q[head_q];
        MemWriteData = data_q[head_q];
    end

    // Load result: forwarded buffer data on a hit, otherwise memory data; zero with no load.
    always_comb begin
        LoadHit  = 1'b0;
        ReadData = '0;
        if (LoadValid) begin
            if (reset && fwd_hit) begin
                LoadHit  = 1'b1;
                ReadData = fwd_data;
            end else begin
                ReadData = MemReadData;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a queue-based model of pending stores plus a
// reference memory predicts every write, forward and flag.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 4;

    // ---------------- clock / reset / signals ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        store_valid = 1'b0;
    logic [31:0] store_address = '0;
    logic [31:0] store_data = '0;
    logic        load_valid = 1'b0;
    logic [31:0] load_address = '0;
    logic        store_ready, load_hit, mem_write, mem_read, empty, full;
    logic [31:0] read_data, mem_address, mem_write_data, mem_read_data;
    logic [2:0]  count;

    bit [31:0]   dmem [256];
    bit [31:0]   ref_mem [256];
    logic [63:0] exp_q [$];
    int          checks = 0;
    int          failures = 0;
    int          write_count = 0;

    always #5 clk = ~clk;

    store_buffer #(.DATA_WIDTH(32), .DEPTH(DEPTH), .PTR_WIDTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .StoreValid   (store_valid),
        .StoreAddress (store_address),
        .StoreData    (store_data),
        .StoreReady   (store_ready),
        .LoadValid    (load_valid),
        .LoadAddress  (load_address),
        .ReadData     (read_data),
        .LoadHit      (load_hit),
        .MemWrite     (mem_write),
        .MemRead      (mem_read),
        .MemAddress   (mem_address),
        .MemWriteData (mem_write_data),
        .MemReadData  (mem_read_data),
        .Empty        (empty),
        .Full         (full),
        .Count        (count)
    );

    // DataMemory stand-in: combinational read, write at the rising edge.
    assign mem_read_data = dmem[mem_address[9:2]];
    always_ff @(posedge clk) begin
        if (mem_write === 1'b1) dmem[mem_address[9:2]] <= mem_write_data;
    end

    // ---------------- reference model ----------------
    function automatic bit model_drain();
        return (reset === 1'b1) && !load_valid && (exp_q.size() != 0);
    endfunction

    function automatic bit model_ready();
        return (reset === 1'b1) && ((exp_q.size() < DEPTH) || model_drain());
    endfunction

    // {hit, data} expected on the load port.
    function automatic logic [32:0] model_load();
        if (!load_valid) return 33'h0;
        if (reset === 1'b1) begin
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i][63:34] == load_address[31:2]) return {1'b1, exp_q[i][31:0]};
            end
        end
        return {1'b0, ref_mem[load_address[9:2]]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rst, input logic sv, input logic [31:0] sa,
                         input logic [31:0] sd, input logic lv, input logic [31:0] la);
        @(negedge clk);
        reset = rst;
        store_valid = sv;
        store_address = sa;
        store_data = sd;
        load_valid = lv;
        load_address = la;
        #1;
    endtask

    // Scoreboard on the write port, then advance one edge and update the model.
    task automatic tick();
        bit drn, enq;
        drn = model_drain();
        enq = store_valid && model_ready();
        checks++;
        if (mem_write !== drn) begin
            failures++;
            $display("FAIL sb_mem_write: got %b want %b", mem_write, drn);
        end
        if (drn) begin
            checks++;
            if ({mem_address, mem_write_data} !== exp_q[0]) begin
                failures++;
                $display("FAIL sb_write_order: got %h/%h want %h/%h",
                         mem_address, mem_write_data, exp_q[0][63:32], exp_q[0][31:0]);
            end
        end
        if (mem_write === 1'b1) write_count++;
        @(posedge clk);
        if (reset !== 1'b1) begin
            exp_q.delete();
        end else begin
            if (drn) begin
                ref_mem[exp_q[0][41:34]] = exp_q[0][31:0];
                void'(exp_q.pop_front());
            end
            if (enq) exp_q.push_back({store_address, store_data});
        end
    endtask

    task automatic drain_all();
        for (int k = 0; k < 2 * DEPTH + 4 && exp_q.size() != 0; k++) begin
            drive(1, 0, 0, 0, 0, 0);
            tick();
        end
        drive(1, 0, 0, 0, 0, 0);
        checks++;
        if (count !== 3'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL drain_done: got count=%0d empty=%b want 0/1", count, empty);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, DATA_BASE_ADDRESS + 32'h100 + 32'(4 * i), $urandom, 1, DATA_BASE_ADDRESS + 32'h3f0);
            tick();
        end
        drive(0, 0, 0, 0, 1, DATA_BASE_ADDRESS + 32'h100);
        checks++;
        if (store_ready !== 1'b0 || load_hit !== 1'b0 || mem_write !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got ready=%b hit=%b wr=%b want 0/0/0", store_ready, load_hit, mem_write);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || mem_write !== 1'b0 || store_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got count=%0d empty=%b wr=%b ready=%b want 0/1/0/0",
                     count, empty, mem_write, store_ready);
        end
        tick();
    endtask

    task automatic test_single_store();
        drive(1, 1, DATA_BASE_ADDRESS + 32'h4, 32'hDEAD_BEEF, 0, 0);
        checks++;
        if (store_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready: got %b want 1", store_ready);
        end
        tick();
        drive(1, 0, 0, 0, 0, 0);
        checks++;
        if (mem_write !== 1'b1 || mem_address !== 32'h1001_0004) begin
            failures++;
            $display("FAIL single_write: got wr=%b addr=%h want 1/10010004", mem_write, mem_address);
        end
        tick();
        drive(1, 0, 0, 0, 0, 0);
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL single_empty: got %b want 1", empty);
        end
        tick();
        drive(1, 0, 0, 0, 1, DATA_BASE_ADDRESS + 32'h4);
        checks++;
        if (load_hit !== 1'b0 || read_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL single_load: got hit=%b data=%h want 0/deadbeef", load_hit, read_data);
        end
        tick();
    endtask

    task automatic test_forwarding();
        logic [31:0] a;
        a = DATA_BASE_ADDRESS + 32'h8;
        drive(1, 1, a, 32'h11, 1, a);
        checks++;
        if (load_hit !== 1'b0 || read_data !== 32'h0) begin
            failures++;
            $display("FAIL fwd_same_cycle: got hit=%b data=%h want 0/0", load_hit, read_data);
        end
        tick();
        drive(1, 1, a, 32'h22, 1, a);
        checks++;
        if (load_hit !== 1'b1 || read_data !== 32'h11) begin
            failures++;
            $display("FAIL fwd_older: got hit=%b data=%h want 1/11", load_hit, read_data);
        end
        tick();
        drive(1, 0, 0, 0, 1, a);
        checks++;
        if (load_hit !== 1'b1 || read_data !== 32'h22 || mem_write !== 1'b0) begin
            failures++;
            $display("FAIL fwd_youngest: got hit=%b data=%h wr=%b want 1/22/0", load_hit, read_data, mem_write);
        end
        tick();
        drain_all();
    endtask

    task automatic test_fill();
        logic [31:0] a5, d5;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, DATA_BASE_ADDRESS + 32'h20 + 32'(4 * i), $urandom, 1, DATA_BASE_ADDRESS + 32'h3f0);
            checks++;
            if (store_ready !== 1'b1) begin
                failures++;
                $display("FAIL fill_ready: store %0d got %b want 1", i, store_ready);
            end
            tick();
        end
        a5 = DATA_BASE_ADDRESS + 32'h30;
        d5 = $urandom;
        drive(1, 1, a5, d5, 1, DATA_BASE_ADDRESS + 32'h3f0);
        checks++;
        if (count !== 3'd4 || full !== 1'b1 || store_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: got count=%0d full=%b ready=%b want 4/1/0", count, full, store_ready);
        end
        tick();
        drive(1, 1, a5, d5, 0, 0);
        checks++;
        if (store_ready !== 1'b1 || mem_write !== 1'b1) begin
            failures++;
            $display("FAIL fill_drain_accept: got ready=%b wr=%b want 1/1", store_ready, mem_write);
        end
        tick();
        drive(1, 0, 0, 0, 1, DATA_BASE_ADDRESS + 32'h3f0);
        checks++;
        if (count !== 3'd4 || full !== 1'b1) begin
            failures++;
            $display("FAIL fill_count_hold: got count=%0d full=%b want 4/1", count, full);
        end
        tick();
        drain_all();
    endtask

    task automatic test_back_to_back();
        write_count = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, DATA_BASE_ADDRESS + 32'(4 * i), 32'(i), 0, 0);
            checks++;
            if (store_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready: store %0d got %b want 1", i, store_ready);
            end
            tick();
        end
        drain_all();
        checks++;
        if (write_count !== 10) begin
            failures++;
            $display("FAIL b2b_writes: got %0d want 10", write_count);
        end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, DATA_BASE_ADDRESS + 32'h180 + 32'(4 * i), $urandom | 32'h1, 1, DATA_BASE_ADDRESS + 32'h3f0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (mem_write !== 1'b0) begin
            failures++;
            $display("FAIL midrst_write: got %b want 0", mem_write);
        end
        tick();
        drive(1, 0, 0, 0, 0, 0);
        checks++;
        if (mem_write !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL midrst_after: got wr=%b empty=%b want 0/1", mem_write, empty);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 1, DATA_BASE_ADDRESS + 32'h180 + 32'(4 * i));
            checks++;
            if (load_hit !== 1'b0 || read_data !== 32'h0) begin
                failures++;
                $display("FAIL midrst_load: entry %0d got hit=%b data=%h want 0/0", i, load_hit, read_data);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic        rst, sv, lv;
        logic [31:0] sa, sd, la;
        logic [32:0] exp_ld;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 60) != 0);
            sv  = 1'($urandom_range(0, 1));
            lv  = ($urandom_range(0, 2) == 0);
            sa  = DATA_BASE_ADDRESS + 32'(4 * $urandom_range(0, 7));
            sd  = $urandom;
            la  = DATA_BASE_ADDRESS + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            drive(rst, sv, sa, sd, lv, la);
            exp_ld = model_load();
            checks++;
            if (store_ready !== model_ready()) begin
                failures++;
                $display("FAIL rnd_ready: cycle %0d got %b want %b", n, store_ready, model_ready());
            end
            checks++;
            if ({load_hit, read_data} !== exp_ld) begin
                failures++;
                $display("FAIL rnd_load: cycle %0d got %b/%h want %b/%h", n, load_hit, read_data, exp_ld[32], exp_ld[31:0]);
            end
            checks++;
            if (count !== 3'(exp_q.size()) || full !== (exp_q.size() == DEPTH) || empty !== (exp_q.size() == 0)) begin
                failures++;
                $display("FAIL rnd_flags: cycle %0d got count=%0d full=%b empty=%b want count=%0d",
                         n, count, full, empty, exp_q.size());
            end
            if (lv) begin
                checks++;
                if (mem_read !== 1'b1 || mem_address !== la) begin
                    failures++;
                    $display("FAIL rnd_load_port: cycle %0d got rd=%b addr=%h want 1/%h", n, mem_read, mem_address, la);
                end
            end
            tick();
        end
        drain_all();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_store();
        test_forwarding();
        test_fill();
        test_back_to_back();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
